// File: rtl/v_load_seq.sv
// Vector load sequencer: packs a serial element stream into lane-aligned, per-lane masked
// register-file writes. Latency from command to done is len + ceil(len/lanes_p) + 1 cycles
// with an unbroken stream. Stream bubbles stall FILL, and commands wait until IDLE.
module v_load_seq #(
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 32,
    parameter int lanes_p = 4,
    localparam int addr_width_lp = (vlen_p == 1) ? 1 : $clog2(vlen_p),
    localparam int len_width_lp  = $clog2(vlen_p + 1),
    localparam int lane_width_lp = (lanes_p == 1) ? 1 : $clog2(lanes_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   cmd_v_i,
    input  logic [len_width_lp-1:0]                cmd_len_i,
    output logic                                   cmd_ready_o,
    input  logic                                   data_v_i,
    input  logic [vdw_p-1:0]                       data_i,
    output logic                                   data_ready_o,
    output logic [lanes_p-1:0][addr_width_lp-1:0]  w_addr_o,
    output logic [lanes_p-1:0][vdw_p-1:0]          w_data_o,
    output logic [lanes_p-1:0]                     w_en_o,
    output logic                                   busy_o,
    output logic                                   done_o
);

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_e;

    state_e                                state_q, state_n;
    logic [len_width_lp-1:0]               len_q, k_q, k_plus1, cmd_len_clamped;
    logic [lanes_p-1:0]                    mask_q;
    logic [lanes_p-1:0][addr_width_lp-1:0] stage_addr_q;
    logic [lanes_p-1:0][vdw_p-1:0]         stage_data_q;
    logic [lane_width_lp-1:0]              lane;
    logic                                  cmd_acc, data_acc, beat_end;

    // Lane is fixed by element index, so every beat starts on a lanes_p boundary.
    assign lane            = (lanes_p == 1) ? '0 : k_q[lane_width_lp-1:0];
    assign k_plus1         = k_q + len_width_lp'(1);
    assign beat_end        = (lane == lane_width_lp'(lanes_p - 1)) || (k_plus1 == len_q);
    assign cmd_len_clamped = (cmd_len_i > len_width_lp'(vlen_p)) ? len_width_lp'(vlen_p) : cmd_len_i;
    assign cmd_acc         = cmd_v_i && (state_q == IDLE);
    assign data_acc        = data_v_i && (state_q == FILL);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        cmd_ready_o  = 1'b0;
        data_ready_o = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        w_en_o       = '0;
        w_addr_o     = '0;
        w_data_o     = '0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_v_i) begin
                    state_n = (cmd_len_clamped == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                data_ready_o = 1'b1;
                if (data_v_i && beat_end) begin
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                w_en_o = mask_q;
                // Unwritten lanes present zeros rather than stale staging contents.
                for (int l = 0; l < lanes_p; l++) begin
                    if (mask_q[l]) begin
                        w_addr_o[l] = stage_addr_q[l];
                        w_data_o[l] = stage_data_q[l];
                    end
                end
                state_n = (k_q < len_q) ? FILL : DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            len_q        <= '0;
            k_q          <= '0;
            mask_q       <= '0;
            stage_addr_q <= '0;
            stage_data_q <= '0;
        end else begin
            if (cmd_acc) begin
                len_q  <= cmd_len_clamped;
                k_q    <= '0;
                mask_q <= '0;
            end
            if (data_acc) begin
                stage_data_q[lane] <= data_i;
                stage_addr_q[lane] <= addr_width_lp'(k_q);
                mask_q[lane]       <= 1'b1;
                k_q                <= k_plus1;
            end
            if (state_q == FLUSH) begin
                mask_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_v_load_seq.sv
// Scoreboard bench for v_load_seq: expected beats are queued per command and matched on each write.
module tb_v_load_seq;

    localparam int VLEN  = 8;
    localparam int VDW   = 32;
    localparam int LANES = 4;
    localparam int AW    = 3;
    localparam int LW    = 4;

    typedef struct {
        logic [LANES-1:0]          en;
        logic [LANES-1:0][AW-1:0]  addr;
        logic [LANES-1:0][VDW-1:0] data;
    } beat_t;

    logic                      clk_i = 1'b0;
    logic                      reset_n_i;
    logic                      cmd_v_i;
    logic [LW-1:0]             cmd_len_i;
    logic                      cmd_ready_o;
    logic                      data_v_i;
    logic [VDW-1:0]            data_i;
    logic                      data_ready_o;
    logic [LANES-1:0][AW-1:0]  w_addr_o;
    logic [LANES-1:0][VDW-1:0] w_data_o;
    logic [LANES-1:0]          w_en_o;
    logic                      busy_o;
    logic                      done_o;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    beat_t exp_q[$];
    int    wr_cyc_q[$];

    v_load_seq #(.vlen_p(VLEN), .vdw_p(VDW), .lanes_p(LANES)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_v_i(cmd_v_i), .cmd_len_i(cmd_len_i), .cmd_ready_o(cmd_ready_o),
        .data_v_i(data_v_i), .data_i(data_i), .data_ready_o(data_ready_o),
        .w_addr_o(w_addr_o), .w_data_o(w_data_o), .w_en_o(w_en_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Every write beat must match the oldest expected beat.
    always @(negedge clk_i) begin
        beat_t e;
        if (w_en_o !== '0) begin
            wr_cyc_q.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write en=%b addr=%h data=%h", w_en_o, w_addr_o, w_data_o);
            end else begin
                e = exp_q.pop_front();
                if (w_en_o !== e.en || w_addr_o !== e.addr || w_data_o !== e.data) begin
                    failures++;
                    $display("FAIL beat en=%b/%b addr=%h/%h data=%h/%h (got/exp)",
                             w_en_o, e.en, w_addr_o, e.addr, w_data_o, e.data);
                end
            end
        end
    end

    function automatic void push_beats(input int len_in, input logic [31:0] base);
        int L;
        L = (len_in > VLEN) ? VLEN : len_in;
        for (int b = 0; b * LANES < L; b++) begin
            beat_t e;
            e.en = '0; e.addr = '0; e.data = '0;
            for (int l = 0; l < LANES; l++) begin
                int k;
                k = b * LANES + l;
                if (k < L) begin
                    e.en[l]   = 1'b1;
                    e.addr[l] = AW'(k);
                    e.data[l] = base + 32'(k);
                end
            end
            exp_q.push_back(e);
        end
    endfunction

    // Drives one command and its stream until done_o; cycles are counted from the accept cycle.
    task automatic run_cmd(input int len_in, input logic [31:0] base, input int navail,
                           input bit bubbles, input bit hold,
                           output int acc_cyc, output int done_cyc, output int consumed,
                           output int n_cmd_acc, output bit dr_seen);
        bit cmd_acc, d_acc, got_done;
        int idx;
        idx = 0; got_done = 0; acc_cyc = -1; done_cyc = -1; n_cmd_acc = 0; dr_seen = 0;
        wr_cyc_q.delete();
        @(negedge clk_i);
        cmd_v_i = 1'b1; cmd_len_i = LW'(len_in); data_v_i = (navail > 0); data_i = base;
        for (int n = 0; n < 300 && !got_done; n++) begin
            cmd_acc = cmd_v_i & cmd_ready_o;
            d_acc   = data_v_i & data_ready_o;
            if (data_ready_o) dr_seen = 1;
            @(posedge clk_i);
            @(negedge clk_i);
            if (cmd_acc) begin
                n_cmd_acc++;
                if (acc_cyc < 0) acc_cyc = cyc - 1;
                if (hold) cmd_len_i = '0;
                else cmd_v_i = 1'b0;
            end
            if (d_acc) idx++;
            if (done_o) begin
                got_done = 1;
                done_cyc = cyc;
            end
            data_i   = base + 32'(idx);
            data_v_i = (idx < navail) && !(bubbles && d_acc);
        end
        consumed = idx;
        if (!got_done) begin
            checks++; failures++;
            $display("FAIL timeout waiting for done_o len=%0d", len_in);
        end
    endtask

    task automatic test_reset;
        reset_n_i = 1'b0; cmd_v_i = 1'b0; cmd_len_i = '0; data_v_i = 1'b0; data_i = '0;
        #1;
        checks++;
        if (cmd_ready_o !== 1'b1 || data_ready_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl cmd_rdy=%b data_rdy=%b busy=%b done=%b exp 1 0 0 0",
                     cmd_ready_o, data_ready_o, busy_o, done_o);
        end
        checks++;
        if (w_en_o !== '0 || w_addr_o !== '0 || w_data_o !== '0) begin
            failures++;
            $display("FAIL reset_write en=%b addr=%h data=%h exp all 0", w_en_o, w_addr_o, w_data_o);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle cmd_rdy=%b busy=%b exp 1 0", cmd_ready_o, busy_o);
        end
    endtask

    task automatic test_back_to_back;
        int a, d, c, n; bit dr;
        push_beats(8, 32'h10);
        run_cmd(8, 32'h10, 8, 0, 0, a, d, c, n, dr);
        checks++;
        if (wr_cyc_q.size() != 2 || wr_cyc_q[0] - a != 5 || wr_cyc_q[1] - a != 10) begin
            failures++;
            $display("FAIL full_beat_timing writes=%0d exp 2 at cycles 5,10", wr_cyc_q.size());
        end
        checks++;
        if (d - a != 11 || c != 8) begin
            failures++;
            $display("FAIL full_done done_cyc=%0d exp 11 consumed=%0d exp 8", d - a, c);
        end
        @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL full_return_idle cmd_rdy=%b done=%b busy=%b exp 1 0 0", cmd_ready_o, done_o, busy_o);
        end
    endtask

    task automatic test_partial;
        int a, d, c, n; bit dr;
        push_beats(5, 32'hA0);
        run_cmd(5, 32'hA0, 5, 0, 0, a, d, c, n, dr);
        checks++;
        if (wr_cyc_q.size() != 2 || d != wr_cyc_q[1] + 1 || d - a != 8) begin
            failures++;
            $display("FAIL partial_timing writes=%0d exp 2 done_cyc=%0d exp 8", wr_cyc_q.size(), d - a);
        end
    endtask

    task automatic test_zero;
        int a, d, c, n; bit dr;
        run_cmd(0, 32'h0, 0, 0, 0, a, d, c, n, dr);
        checks++;
        if (d - a != 1 || wr_cyc_q.size() != 0 || dr !== 1'b0) begin
            failures++;
            $display("FAIL zero_len done_cyc=%0d exp 1 writes=%0d exp 0 data_rdy_seen=%b exp 0",
                     d - a, wr_cyc_q.size(), dr);
        end
    endtask

    task automatic test_clamp;
        int a, d, c, n; bit dr;
        push_beats(12, 32'hC0);
        run_cmd(12, 32'hC0, 12, 0, 0, a, d, c, n, dr);
        checks++;
        if (c != 8 || d - a != 11) begin
            failures++;
            $display("FAIL clamp consumed=%0d exp 8 done_cyc=%0d exp 11", c, d - a);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            checks++;
            if (data_ready_o !== 1'b0 || data_v_i !== 1'b1) begin
                failures++;
                $display("FAIL clamp_excess data_rdy=%b exp 0 data_v=%b exp 1", data_ready_o, data_v_i);
            end
        end
        data_v_i = 1'b0;
    endtask

    task automatic test_bubbles_held_cmd;
        int a, d, c, n; bit dr;
        push_beats(4, 32'h30);
        run_cmd(4, 32'h30, 4, 1, 1, a, d, c, n, dr);
        checks++;
        if (wr_cyc_q.size() != 1 || wr_cyc_q[0] - a != 8 || d - a != 9 || n != 1) begin
            failures++;
            $display("FAIL bubbles writes=%0d exp 1 done_cyc=%0d exp 9 cmd_accepts=%0d exp 1",
                     wr_cyc_q.size(), d - a, n);
        end
        checks++;
        if (cmd_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL held_cmd_in_done cmd_rdy=%b exp 0", cmd_ready_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1 || cmd_v_i !== 1'b1) begin
            failures++;
            $display("FAIL held_cmd_after_done cmd_rdy=%b exp 1", cmd_ready_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_v_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL held_cmd_accept done=%b busy=%b exp 1 1", done_o, busy_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid;
        int a, d, c, n; bit dr;
        @(negedge clk_i);
        cmd_v_i = 1'b1; cmd_len_i = LW'(8); data_v_i = 1'b1; data_i = 32'h50;
        @(negedge clk_i);
        cmd_v_i = 1'b0;
        @(negedge clk_i);
        data_i = 32'h51;
        @(negedge clk_i);
        data_v_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || data_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_fill busy=%b data_rdy=%b exp 1 1", busy_o, data_ready_o);
        end
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (w_en_o !== '0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || data_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset en=%b busy=%b cmd_rdy=%b data_rdy=%b exp 0 0 1 0",
                     w_en_o, busy_o, cmd_ready_o, data_ready_o);
        end
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        push_beats(4, 32'h60);
        run_cmd(4, 32'h60, 4, 0, 0, a, d, c, n, dr);
        checks++;
        if (c != 4 || d - a != 6 || wr_cyc_q.size() != 1) begin
            failures++;
            $display("FAIL after_reset consumed=%0d exp 4 done_cyc=%0d exp 6 writes=%0d exp 1",
                     c, d - a, wr_cyc_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_partial();
        test_zero();
        test_clamp();
        test_bubbles_held_cmd();
        test_reset_mid();
        repeat (2) @(negedge clk_i);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain leftover=%0d exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
